// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table predictor.
package bp_pkg;

  localparam int unsigned MAX_IDX_BITS = 16;

  typedef logic [1:0] ctr_t;

  localparam ctr_t STRONG_NT = 2'd0;
  localparam ctr_t WEAK_NT   = 2'd1;
  localparam ctr_t WEAK_T    = 2'd2;
  localparam ctr_t STRONG_T  = 2'd3;

  typedef enum logic {StInit, StRun} bp_state_e;

  typedef struct packed {
    logic [MAX_IDX_BITS-1:0] index;
    logic                    taken;
    logic                    mispred;
  } upd_entry_t;

  // Saturating 2-bit counter step.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    if (taken) begin
      return (c == STRONG_T) ? STRONG_T : c + 2'd1;
    end
    return (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Update FIFO: two enqueue slots (a ahead of b), one dequeue, registered free count.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_push_a,
  input  upd_entry_t                 i_data_a,
  input  logic                       i_push_b,
  input  upd_entry_t                 i_data_b,
  input  logic                       i_pop,
  output logic                       o_acc_a,
  output logic                       o_acc_b,
  output upd_entry_t                 o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  upd_entry_t            r_mem [DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_count;

  logic [CntW-1:0]       w_free;
  logic [CntW-1:0]       w_need_b;
  logic                  w_pop;
  logic [PtrW-1:0]       w_wr_ptr_b;

  // Space is judged on the registered count only; a same-cycle pop gives no credit.
  assign w_free     = CntW'(DEPTH) - r_count;
  assign o_acc_a    = i_push_a && (w_free != '0);
  assign w_need_b   = o_acc_a ? CntW'(2) : CntW'(1);
  assign o_acc_b    = i_push_b && (w_free >= w_need_b);
  assign w_pop      = i_pop && (r_count != '0);
  assign w_wr_ptr_b = r_wr_ptr + PtrW'(o_acc_a);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_free  = w_free;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PtrW'(o_acc_a) + PtrW'(o_acc_b);
      r_rd_ptr <= r_rd_ptr + PtrW'(w_pop);
      r_count  <= r_count + CntW'(o_acc_a) + CntW'(o_acc_b) - CntW'(w_pop);
    end
  end

  always_ff @(posedge i_clock) begin
    if (o_acc_a) r_mem[r_wr_ptr] <= i_data_a;
    if (o_acc_b) r_mem[w_wr_ptr_b] <= i_data_b;
  end

endmodule

// File: rtl/bht_predictor.sv
// Dual-slot bimodal branch predictor with buffered single-port table updates.
// Define BHT_STATS_EN to build the applied-update / mispredict statistic counters.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_pc_top,
  input  logic [31:0] i_pc_bot,
  output logic        o_predict_top,
  output logic        o_predict_bot,
  input  logic        i_upd_valid_top,
  input  logic        i_upd_valid_bot,
  input  logic [31:0] i_upd_pc_top,
  input  logic [31:0] i_upd_pc_bot,
  input  logic        i_upd_taken_top,
  input  logic        i_upd_taken_bot,
  input  logic        i_upd_mispred_top,
  input  logic        i_upd_mispred_bot,
  output logic        o_upd_ready,
  output logic        o_bht_ready,
  output logic        o_overflow_err,
  output logic [31:0] o_update_count,
  output logic [31:0] o_mispred_count
);

  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam int unsigned FreeW   = $clog2(FIFO_DEPTH) + 1;

  bp_state_e             r_state;
  bp_state_e             w_state_d;
  logic [INDEX_BITS-1:0] r_init_idx;
  ctr_t                  r_table [Entries];
  logic                  r_overflow;

  logic                  w_run;
  upd_entry_t            w_entry_top;
  upd_entry_t            w_entry_bot;
  upd_entry_t            w_head;
  logic                  w_acc_top;
  logic                  w_acc_bot;
  logic                  w_fifo_empty;
  logic [FreeW-1:0]      w_free;
  logic                  w_apply;
  logic                  w_we;
  logic [INDEX_BITS-1:0] w_waddr;
  ctr_t                  w_wdata;

  assign w_run   = (r_state == StRun);
  assign w_apply = w_run && !w_fifo_empty;

  assign w_entry_top = '{index:   MAX_IDX_BITS'(i_upd_pc_top[INDEX_BITS-1:0]),
                         taken:   i_upd_taken_top,
                         mispred: i_upd_mispred_top};
  assign w_entry_bot = '{index:   MAX_IDX_BITS'(i_upd_pc_bot[INDEX_BITS-1:0]),
                         taken:   i_upd_taken_bot,
                         mispred: i_upd_mispred_bot};

  bp_update_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_push_a (w_run && i_upd_valid_top),
    .i_data_a (w_entry_top),
    .i_push_b (w_run && i_upd_valid_bot),
    .i_data_b (w_entry_bot),
    .i_pop    (w_run),
    .o_acc_a  (w_acc_top),
    .o_acc_b  (w_acc_bot),
    .o_head   (w_head),
    .o_empty  (w_fifo_empty),
    .o_free   (w_free)
  );

  always_comb begin
    w_state_d = r_state;
    if (r_state == StInit && r_init_idx == '1) begin
      w_state_d = StRun;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= StInit;
      r_init_idx <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StInit) r_init_idx <= r_init_idx + 1'b1;
      if (w_run && ((i_upd_valid_top && !w_acc_top) || (i_upd_valid_bot && !w_acc_bot))) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Single write port: init sweep, else the FIFO head against the pre-write counter.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_idx;
    w_wdata = COUNTER_INIT;
    if (!i_reset) begin
      if (r_state == StInit) begin
        w_we = 1'b1;
      end else if (!w_fifo_empty) begin
        w_we    = 1'b1;
        w_waddr = w_head.index[INDEX_BITS-1:0];
        w_wdata = ctr_next(r_table[w_head.index[INDEX_BITS-1:0]], w_head.taken);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_we) r_table[w_waddr] <= w_wdata;
  end

  assign o_predict_top  = w_run && r_table[i_pc_top[INDEX_BITS-1:0]][1];
  assign o_predict_bot  = w_run && r_table[i_pc_bot[INDEX_BITS-1:0]][1];
  assign o_upd_ready    = w_run && (w_free >= FreeW'(2));
  assign o_bht_ready    = w_run;
  assign o_overflow_err = r_overflow;

`ifdef BHT_STATS_EN
  logic [31:0] r_update_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_update_count  <= '0;
      r_mispred_count <= '0;
    end else if (!i_reset && w_apply) begin
      if (r_update_count != '1) r_update_count <= r_update_count + 32'd1;
      if (w_head.mispred && r_mispred_count != '1) r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign o_update_count  = r_update_count;
  assign o_mispred_count = r_mispred_count;

  logic w_unused;
  assign w_unused = ^{i_pc_top, i_pc_bot, i_upd_pc_top, i_upd_pc_bot, w_head.index};
`else
  assign o_update_count  = '0;
  assign o_mispred_count = '0;

  logic w_unused;
  assign w_unused = ^{i_pc_top, i_pc_bot, i_upd_pc_top, i_upd_pc_bot, w_head.index,
                      w_head.mispred, w_apply};
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Randomised bench for bht_predictor against a queue/array reference model.
module tb_bht_predictor;

  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_top, pc_bot, upd_pc_top, upd_pc_bot;
  logic        vt, vb, tt, tb, mt, mb;
  logic        pred_top, pred_bot, upd_ready, bht_ready, ovf;
  logic [31:0] upd_cnt, mis_cnt;

  always #5 clk = ~clk;

  bht_predictor dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_pc_top          (pc_top),
    .i_pc_bot          (pc_bot),
    .o_predict_top     (pred_top),
    .o_predict_bot     (pred_bot),
    .i_upd_valid_top   (vt),
    .i_upd_valid_bot   (vb),
    .i_upd_pc_top      (upd_pc_top),
    .i_upd_pc_bot      (upd_pc_bot),
    .i_upd_taken_top   (tt),
    .i_upd_taken_bot   (tb),
    .i_upd_mispred_top (mt),
    .i_upd_mispred_bot (mb),
    .o_upd_ready       (upd_ready),
    .o_bht_ready       (bht_ready),
    .o_overflow_err    (ovf),
    .o_update_count    (upd_cnt),
    .o_mispred_count   (mis_cnt)
  );

  typedef struct {int idx; bit taken; bit mis;} upd_t;

  upd_t    q[$];
  int      tbl[N];
  bit      m_run;
  int      m_init;
  bit      m_ovf;
  longint  m_uc, m_mc;
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   free;
    bit   have;
    upd_t h;
    upd_t e;
    if (rst) begin
      q.delete();
      m_init = 0; m_run = 0; m_ovf = 0; m_uc = 0; m_mc = 0;
    end else if (!m_run) begin
      tbl[m_init] = 1;
      m_init++;
      if (m_init == N) m_run = 1;
    end else begin
      free = DEPTH - q.size();
      have = q.size() > 0;
      if (have) h = q.pop_front();
      if (vt) begin
        if (free > 0) begin
          e.idx = int'(upd_pc_top % N); e.taken = tt; e.mis = mt;
          q.push_back(e); free--;
        end else m_ovf = 1;
      end
      if (vb) begin
        if (free > 0) begin
          e.idx = int'(upd_pc_bot % N); e.taken = tb; e.mis = mb;
          q.push_back(e); free--;
        end else m_ovf = 1;
      end
      if (have) begin
        if (h.taken) tbl[h.idx] = (tbl[h.idx] >= 3) ? 3 : tbl[h.idx] + 1;
        else         tbl[h.idx] = (tbl[h.idx] <= 0) ? 0 : tbl[h.idx] - 1;
`ifdef BHT_STATS_EN
        if (m_uc < 64'hFFFF_FFFF) m_uc++;
        if (h.mis && m_mc < 64'hFFFF_FFFF) m_mc++;
`endif
      end
    end
  endtask

  task automatic compare_outputs();
    chk("predict_top", pred_top, m_run ? (tbl[pc_top % N] >> 1) : 0);
    chk("predict_bot", pred_bot, m_run ? (tbl[pc_bot % N] >> 1) : 0);
    chk("upd_ready", upd_ready, (m_run && (DEPTH - q.size()) >= 2) ? 1 : 0);
    chk("bht_ready", bht_ready, m_run);
    chk("overflow_err", ovf, m_ovf);
    chk("update_count", upd_cnt, m_uc);
    chk("mispred_count", mis_cnt, m_mc);
  endtask

  // Entered just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    #1 compare_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    vt = 0; vb = 0; tt = 0; tb = 0; mt = 0; mb = 0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int cyc;
    bit throttle;
    rst = 1; pc_top = 0; pc_bot = 0; upd_pc_top = 0; upd_pc_bot = 0;
    idle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_bht_ready", bht_ready, 0);
    chk("reset_upd_ready", upd_ready, 0);
    chk("reset_overflow", ovf, 0);

    // Init length from reset release
    cyc = 0;
    while (!bht_ready && cyc < 200) begin
      pc_top = $urandom; pc_bot = $urandom;
      cycle();
      cyc++;
    end
    chk("init_cycles", cyc, 64);

    // Saturating counter on idx 5, read through aliasing pc 0x45
    pc_top = 32'h06; pc_bot = 32'h45;
    upd_pc_top = 32'h05; vt = 1; tt = 1;
    for (int i = 0; i < 3; i++) cycle();
    idle_cycles(2);
    #1 chk("idx5_after3_taken", pred_bot, 1);
    chk("idx6_untouched", pred_top, 0);
    vt = 1; tt = 1; cycle();
    idle_cycles(2);
    #1 chk("idx5_after4_taken", pred_bot, 1);
    vt = 1; tt = 0; cycle();
    idle_cycles(2);
    #1 chk("idx5_one_nt", pred_bot, 1);
    vt = 1; tt = 0; cycle();
    idle_cycles(2);
    #1 chk("idx5_two_nt", pred_bot, 0);

    // Dual update ordering: top applied one edge before bot
    upd_pc_top = 32'd3; upd_pc_bot = 32'd9; vt = 1; vb = 1; tt = 1; tb = 1;
    pc_top = 32'd3; pc_bot = 32'd9;
    cycle();
    idle();
    #1 chk("idx3_at_enq", pred_top, 0);
    chk("idx9_at_enq", pred_bot, 0);
    cycle();
    #1 chk("idx3_edge1", pred_top, 1);
    chk("idx9_edge1", pred_bot, 0);
    cycle();
    #1 chk("idx9_edge2", pred_bot, 1);

    // Back-pressure and sticky overflow
    pc_top = 32'd20;
    upd_pc_top = 32'd20; upd_pc_bot = 32'd20; vt = 1; vb = 1; tt = 1; tb = 1;
    #1 chk("ready_empty", upd_ready, 1);
    cycle();
    #1 chk("ready_cnt2", upd_ready, 1);
    chk("ovf_cnt2", ovf, 0);
    cycle();
    #1 chk("ready_cnt3", upd_ready, 0);
    chk("ovf_cnt3", ovf, 0);
    cycle();
    #1 chk("ovf_set", ovf, 1);

    // Reset with three entries pending: none may reach the table
    idle(); upd_pc_top = 32'd21; upd_pc_bot = 32'd21;
    rst = 1; cycle(); rst = 0;
    #1 chk("rst_ovf_clear", ovf, 0);
    chk("rst_bht_ready", bht_ready, 0);
    chk("rst_upd_ready", upd_ready, 0);
    idle_cycles(64);
    #1 chk("reinit_done", bht_ready, 1);
    chk("idx20_reinit", pred_top, 0);
    idle_cycles(4);
    #1 chk("idx20_no_stale", pred_top, 0);

    // Statistics: five applied updates, two mispredicted
    for (int i = 0; i < 5; i++) begin
      upd_pc_top = 32'd30 + i; vt = 1; tt = i[0]; mt = (i == 1 || i == 4);
      cycle();
    end
    idle_cycles(3);
`ifdef BHT_STATS_EN
    #1 chk("stats_updates", upd_cnt, 5);
    chk("stats_mispred", mis_cnt, 2);
`else
    #1 chk("stats_updates_off", upd_cnt, 0);
    chk("stats_mispred_off", mis_cnt, 0);
`endif

    // Random traffic with colliding indices, occasional reset
    throttle = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) throttle = ~throttle;
      pc_top = {$urandom_range(0, 3), 26'd0, 6'($urandom_range(0, 15))};
      pc_bot = {$urandom_range(0, 3), 26'd0, 6'($urandom_range(0, 15))};
      upd_pc_top = {$urandom, 6'd0} | 32'($urandom_range(0, 15));
      upd_pc_bot = {$urandom, 6'd0} | 32'($urandom_range(0, 15));
      vt = ($urandom_range(0, 2) != 0);
      vb = ($urandom_range(0, 2) == 0);
      if (throttle && !upd_ready) begin vt = 0; vb = 0; end
      tt = $urandom_range(0, 1); tb = $urandom_range(0, 1);
      mt = $urandom_range(0, 1); mb = $urandom_range(0, 1);
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 0;
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 6, log2 of table entries (64 two-bit counters).
REQ-002 Parameter FIFO_DEPTH, default 4, update-FIFO entries, power of two, >=2.
REQ-003 Parameter COUNTER_INIT, default 2'b01, counter value loaded at init (weakly not-taken).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 pc_top, pc_bot  in  32  fetch PCs of top/bottom issue slots, word-addressed.
REQ-008 predict_top, predict_bot  out  1  taken prediction per slot.
REQ-009 upd_valid_top, upd_valid_bot  in  1  resolved-branch update request per slot.
REQ-010 upd_pc_top, upd_pc_bot  in  32  PC of resolved branch.
REQ-011 upd_taken_top, upd_taken_bot  in  1  actual outcome.
REQ-012 upd_mispred_top, upd_mispred_bot  in  1  prediction was wrong.
REQ-013 upd_ready  out  1  both update slots may be asserted this cycle.
REQ-014 bht_ready  out  1  initialisation complete.
REQ-015 overflow_err  out  1  sticky: update dropped on full FIFO.
REQ-016 update_count, mispred_count  out  32  statistics (see Configuration).

Function
REQ-017 Index = pc[INDEX_BITS-1:0]; predict_x = table[index][1], combinational read, zero latency.
REQ-018 Reads return table contents before any write in the same cycle; no bypass.
REQ-019 FSM states INIT, RUN; INIT writes COUNTER_INIT to entry init_idx each cycle, init_idx 0..2^INDEX_BITS-1, then RUN.
REQ-020 INIT lasts exactly 2^INDEX_BITS cycles after reset deasserts; bht_ready, upd_ready, predict_* are 0 in INIT.
REQ-021 In RUN, valid updates enqueue into FIFO same edge; both valid -> top enqueued ahead of bot.
REQ-022 upd_ready = RUN and free entries >= 2, registered-free-count based (no same-cycle pop credit).
REQ-023 Update arriving with insufficient space is dropped, overflow_err set until reset; other slot still enqueued if one entry free (top priority).
REQ-024 Single write port: FIFO head popped and applied once per cycle when non-empty, so update latency to table is >=1 cycle after enqueue.
REQ-025 Counter arithmetic saturating 2-bit: taken -> min(c+1,3), not-taken -> max(c-1,0).
REQ-026 Head write and simultaneous enqueue of same index are independent; later entry applies to post-write value next cycle.
REQ-027 Simultaneous enqueue and pop on full FIFO: pop does not free space for that cycle's enqueue.
REQ-028 Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.

Reset
REQ-029 reset (any cycle, including mid-INIT or with FIFO occupied): FIFO emptied, pointers/count 0, init_idx 0, state INIT, overflow_err 0, statistic counters 0.
REQ-030 Table contents undefined during reset; only INIT guarantees values.

Configuration
REQ-031 Macro BHT_STATS_EN defined: update_count increments per applied (popped) update, mispred_count per applied update with mispred=1, both saturating at 32'hFFFFFFFF.
REQ-032 BHT_STATS_EN undefined: counter registers absent, update_count and mispred_count tied to 0; mispred inputs unused.

Structure
REQ-033 Package bp_pkg holds: 2-bit counter typedef, FSM state enum (INIT, RUN), update-entry struct (index, taken, mispred), constants STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3.
REQ-034 Sub-module bp_update_fifo: dual-enqueue, single-dequeue FIFO with free count; table, FSM, counters in top.

Verification
REQ-035 Reset 1 cycle then release -> bht_ready rises exactly 64 cycles later; all predict_* 0 for any PC.
REQ-036 Three taken updates to pc 0x05 -> counter 1->2->3, predict for pc 0x45 (aliases idx 5) =1; fourth taken keeps 3.
REQ-037 Both slots update idx 3 and idx 9 same cycle -> idx 3 written next edge, idx 9 one edge later.
REQ-038 Hold both upd_valid high without draining stall -> upd_ready drops when free<2; forced extra update -> overflow_err=1 sticky.
REQ-039 Reset asserted with 3 FIFO entries pending mid-RUN -> FIFO empty, INIT restarts, no pending write reaches table.
REQ-040 BHT_STATS_EN: 5 updates, 2 mispredicted -> update_count=5, mispred_count=2; undefined -> both 0.
